rr_arbiter3: RTL and testbench

Round-robin arbiter that shares one single-user resource (a counter/datapath stage) between three requesters. Each requester raises a level request. The arbiter grants one requester at a time with a registered one-hot grant and holds it until the request drops or a hold limit expires. Priority rotates with a mod-3 pointer, so no requester starves. The block sits between the requesting units and the shared resource, and its `grant` bits drive the resource's input enables.

---
 rtl/rr_arbiter3.sv | 146 ++++++++++++++
 tb/tb_rr_arbiter3.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter3.sv
// Round-robin arbiter: three level requesters share one resource through a registered one-hot grant.
// Latency: grant is visible right after the IDLE edge that samples req; hold is capped at HOLD_MAX cycles.
// Backpressure: none; requesters simply keep req high and wait. A revoked owner sees two idle cycles.
module rr_arbiter3 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [2:0] grant,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Last value of the hold counter; the grant is revoked on the edge where cnt already sits here.
  localparam logic [3:0] CNT_LAST = 4'(HOLD_MAX - 1);

  state_t     r_state;
  logic [1:0] r_ptr;
  logic [3:0] r_cnt;
  logic [2:0] r_grant;
  logic [1:0] r_grant_id;
  logic       r_busy;
  logic       r_timeout;

  logic       w_win_vld;
  logic [1:0] w_win_id;
  logic [1:0] w_ptr_next;
  logic [2:0] w_win_onehot;
  logic       w_owner_req;

  // Pick the first requester at or after the rotating pointer (search order ptr, ptr+1, ptr+2 mod 3).
  always_comb begin
    w_win_vld = |req;
    w_win_id  = 2'd0;
    case (r_ptr)
      2'd1: begin
        if (req[1])      w_win_id = 2'd1;
        else if (req[2]) w_win_id = 2'd2;
        else             w_win_id = 2'd0;
      end
      2'd2: begin
        if (req[2])      w_win_id = 2'd2;
        else if (req[0]) w_win_id = 2'd0;
        else             w_win_id = 2'd1;
      end
      default: begin
        if (req[0])      w_win_id = 2'd0;
        else if (req[1]) w_win_id = 2'd1;
        else             w_win_id = 2'd2;
      end
    endcase
  end

  // Pointer moves to the requester just after the winner, wrapping 2 back to 0.
  always_comb begin
    w_ptr_next   = 2'd0;
    w_win_onehot = 3'b000;
    case (w_win_id)
      2'd0: begin
        w_ptr_next   = 2'd1;
        w_win_onehot = 3'b001;
      end
      2'd1: begin
        w_ptr_next   = 2'd2;
        w_win_onehot = 3'b010;
      end
      default: begin
        w_ptr_next   = 2'd0;
        w_win_onehot = 3'b100;
      end
    endcase
  end

  // The current owner is still requesting when its grant bit lines up with a high req bit.
  assign w_owner_req = |(req & r_grant);

  // Arbiter state machine; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 2'd0;
      r_cnt      <= 4'd0;
      r_grant    <= 3'b000;
      r_grant_id <= 2'd0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_timeout <= 1'b0;
          if (w_win_vld) begin
            r_grant    <= w_win_onehot;
            r_grant_id <= w_win_id;
            r_busy     <= 1'b1;
            r_cnt      <= 4'd0;
            r_ptr      <= w_ptr_next;
            r_state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // A dropped request wins over the hold limit, so a voluntary release never flags timeout.
          if (!w_owner_req) begin
            r_grant   <= 3'b000;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_state   <= ST_RELEASE;
          end else if (r_cnt == CNT_LAST) begin
            r_grant   <= 3'b000;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= ST_RELEASE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_RELEASE: begin
          // One dead cycle; requests are deliberately not looked at here.
          r_grant   <= 3'b000;
          r_busy    <= 1'b0;
          r_timeout <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_grant   <= 3'b000;
          r_busy    <= 1'b0;
          r_timeout <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant    = r_grant;
  assign grant_id = r_grant_id;
  assign busy     = r_busy;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_rr_arbiter3.sv
// Bench for rr_arbiter3: two instances (HOLD_MAX=4 and HOLD_MAX=1) share one stimulus stream.
// Hand-derived vector tables cover the directed corner cases; a transaction-level model checks every cycle.
// Inputs change #1 after the rising edge; outputs are sampled #1 after the edge.
module tb_rr_arbiter3;

  logic       clk;
  logic       rst;
  logic [2:0] req;

  logic [2:0] g4, g1;
  logic [1:0] id4, id1;
  logic       b4, b1;
  logic       t4, t1;

  int checks;
  int errors;

  rr_arbiter3 #(.HOLD_MAX(4)) dut4 (
    .clk(clk), .rst(rst), .req(req),
    .grant(g4), .grant_id(id4), .busy(b4), .timeout(t4)
  );

  rr_arbiter3 #(.HOLD_MAX(1)) dut1 (
    .clk(clk), .rst(rst), .req(req),
    .grant(g1), .grant_id(id1), .busy(b1), .timeout(t1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic [2:0] grant;
    logic [1:0] gid;
    logic       busy;
    logic       to;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [2:0] q, input logic [2:0] g,
                              input logic [1:0] id, input logic b, input logic t);
    vec_t v;
    v.rst = r; v.req = q; v.grant = g; v.gid = id; v.busy = b; v.to = t;
    return v;
  endfunction

  // Transaction-level reference: who owns the resource, for how many cycles, and how long the cooldown lasts.
  int m_hmax [2] = '{4, 1};
  int m_owner[2];
  int m_held [2];
  int m_gap  [2];
  int m_nxt  [2];
  int m_last [2];
  bit m_to   [2];

  task automatic model_step(input int m, input logic r, input logic [2:0] q);
    bit found;
    int i;
    if (r) begin
      m_owner[m] = -1; m_held[m] = 0; m_gap[m] = 0; m_nxt[m] = 0; m_last[m] = 0; m_to[m] = 0;
    end else if (m_owner[m] >= 0) begin
      if (!q[m_owner[m]]) begin
        m_owner[m] = -1; m_gap[m] = 1; m_to[m] = 0;
      end else if (m_held[m] == m_hmax[m]) begin
        m_owner[m] = -1; m_gap[m] = 1; m_to[m] = 1;
      end else begin
        m_held[m] = m_held[m] + 1;
      end
    end else if (m_gap[m] > 0) begin
      m_gap[m] = m_gap[m] - 1;
      m_to[m]  = 0;
    end else begin
      m_to[m] = 0;
      found = 0;
      for (int k = 0; k < 3; k++) begin
        i = (m_nxt[m] + k) % 3;
        if (!found && q[i]) begin
          found      = 1;
          m_owner[m] = i;
          m_last[m]  = i;
          m_held[m]  = 1;
          m_nxt[m]   = (i + 1) % 3;
        end
      end
    end
  endtask

  function automatic logic [6:0] model_out(input int m);
    logic [2:0] g;
    g = 3'b000;
    if (m_owner[m] >= 0) g[m_owner[m]] = 1'b1;
    return {g, 2'(m_last[m]), (m_owner[m] >= 0), m_to[m]};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got grant=%b id=%0d busy=%b to=%b want grant=%b id=%0d busy=%b to=%b",
               name, act[6:4], act[3:2], act[1], act[0], exp[6:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  // Apply one cycle of stimulus, advance the models, and compare both instances against them.
  task automatic step(input logic r, input logic [2:0] q, input string tag);
    rst = r;
    req = q;
    @(posedge clk);
    #1;
    model_step(0, r, q);
    model_step(1, r, q);
    check({tag, "/model4"}, {g4, id4, b4, t4}, model_out(0));
    check({tag, "/model1"}, {g1, id1, b1, t1}, model_out(1));
  endtask

  vec_t tab4[$];
  vec_t tab1[$];

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    req = 3'b000;
    for (int m = 0; m < 2; m++) begin
      m_owner[m] = -1; m_held[m] = 0; m_gap[m] = 0; m_nxt[m] = 0; m_last[m] = 0; m_to[m] = 0;
    end

    // HOLD_MAX=4: reset, full-load rotation, early release, pointer wrap, reset mid-grant, late req.
    tab4.push_back(mk(1, 3'b111, 3'b000, 2'd0, 0, 0));
    tab4.push_back(mk(1, 3'b111, 3'b000, 2'd0, 0, 0));
    tab4.push_back(mk(0, 3'b111, 3'b001, 2'd0, 1, 0));
    tab4.push_back(mk(0, 3'b111, 3'b001, 2'd0, 1, 0));
    tab4.push_back(mk(0, 3'b111, 3'b001, 2'd0, 1, 0));
    tab4.push_back(mk(0, 3'b111, 3'b001, 2'd0, 1, 0));
    tab4.push_back(mk(0, 3'b111, 3'b000, 2'd0, 0, 1));
    tab4.push_back(mk(0, 3'b111, 3'b000, 2'd0, 0, 0));
    tab4.push_back(mk(0, 3'b111, 3'b010, 2'd1, 1, 0));
    tab4.push_back(mk(0, 3'b111, 3'b010, 2'd1, 1, 0));
    tab4.push_back(mk(0, 3'b111, 3'b010, 2'd1, 1, 0));
    tab4.push_back(mk(0, 3'b111, 3'b010, 2'd1, 1, 0));
    tab4.push_back(mk(0, 3'b111, 3'b000, 2'd1, 0, 1));
    tab4.push_back(mk(0, 3'b111, 3'b000, 2'd1, 0, 0));
    tab4.push_back(mk(0, 3'b111, 3'b100, 2'd2, 1, 0));
    tab4.push_back(mk(0, 3'b111, 3'b100, 2'd2, 1, 0));
    tab4.push_back(mk(0, 3'b111, 3'b100, 2'd2, 1, 0));
    tab4.push_back(mk(0, 3'b111, 3'b100, 2'd2, 1, 0));
    tab4.push_back(mk(0, 3'b111, 3'b000, 2'd2, 0, 1));
    tab4.push_back(mk(0, 3'b111, 3'b000, 2'd2, 0, 0));
    tab4.push_back(mk(0, 3'b111, 3'b001, 2'd0, 1, 0));
    // early release from ptr=0
    tab4.push_back(mk(1, 3'b000, 3'b000, 2'd0, 0, 0));
    tab4.push_back(mk(0, 3'b000, 3'b000, 2'd0, 0, 0));
    tab4.push_back(mk(0, 3'b010, 3'b010, 2'd1, 1, 0));
    tab4.push_back(mk(0, 3'b010, 3'b010, 2'd1, 1, 0));
    tab4.push_back(mk(0, 3'b000, 3'b000, 2'd1, 0, 0));
    tab4.push_back(mk(0, 3'b000, 3'b000, 2'd1, 0, 0));
    // pointer wrap with ptr=2, req=101 held one cycle per grant
    tab4.push_back(mk(0, 3'b101, 3'b100, 2'd2, 1, 0));
    tab4.push_back(mk(0, 3'b000, 3'b000, 2'd2, 0, 0));
    tab4.push_back(mk(0, 3'b000, 3'b000, 2'd2, 0, 0));
    tab4.push_back(mk(0, 3'b101, 3'b001, 2'd0, 1, 0));
    tab4.push_back(mk(0, 3'b000, 3'b000, 2'd0, 0, 0));
    tab4.push_back(mk(0, 3'b000, 3'b000, 2'd0, 0, 0));
    // ptr=1 now, so 101 resolves to requester 2; hold it to cnt=2
    tab4.push_back(mk(0, 3'b101, 3'b100, 2'd2, 1, 0));
    tab4.push_back(mk(0, 3'b100, 3'b100, 2'd2, 1, 0));
    tab4.push_back(mk(0, 3'b100, 3'b100, 2'd2, 1, 0));
    // reset mid-grant: immediate clear, no timeout, grant reissued afterwards
    tab4.push_back(mk(1, 3'b100, 3'b000, 2'd0, 0, 0));
    tab4.push_back(mk(0, 3'b100, 3'b100, 2'd2, 1, 0));
    // other requesters are ignored while granted; owner drop releases
    tab4.push_back(mk(0, 3'b011, 3'b000, 2'd2, 0, 0));
    tab4.push_back(mk(0, 3'b011, 3'b000, 2'd2, 0, 0));
    tab4.push_back(mk(0, 3'b011, 3'b001, 2'd0, 1, 0));
    // a req high only during RELEASE is never granted
    tab4.push_back(mk(0, 3'b000, 3'b000, 2'd0, 0, 0));
    tab4.push_back(mk(0, 3'b010, 3'b000, 2'd0, 0, 0));
    tab4.push_back(mk(0, 3'b000, 3'b000, 2'd0, 0, 0));
    tab4.push_back(mk(0, 3'b000, 3'b000, 2'd0, 0, 0));

    for (int i = 0; i < tab4.size(); i++) begin
      step(tab4[i].rst, tab4[i].req, $sformatf("t4[%0d]", i));
      check($sformatf("t4[%0d]/table", i), {g4, id4, b4, t4},
            {tab4[i].grant, tab4[i].gid, tab4[i].busy, tab4[i].to});
    end

    // HOLD_MAX=1: req0 held, req2 rises during RELEASE, next grant goes to 2 since ptr=1.
    tab1.push_back(mk(1, 3'b000, 3'b000, 2'd0, 0, 0));
    tab1.push_back(mk(0, 3'b001, 3'b001, 2'd0, 1, 0));
    tab1.push_back(mk(0, 3'b001, 3'b000, 2'd0, 0, 1));
    tab1.push_back(mk(0, 3'b101, 3'b000, 2'd0, 0, 0));
    tab1.push_back(mk(0, 3'b101, 3'b100, 2'd2, 1, 0));
    tab1.push_back(mk(0, 3'b101, 3'b000, 2'd2, 0, 1));
    tab1.push_back(mk(0, 3'b101, 3'b000, 2'd2, 0, 0));
    tab1.push_back(mk(0, 3'b101, 3'b001, 2'd0, 1, 0));
    tab1.push_back(mk(0, 3'b000, 3'b000, 2'd0, 0, 0));

    for (int i = 0; i < tab1.size(); i++) begin
      step(tab1[i].rst, tab1[i].req, $sformatf("t1[%0d]", i));
      check($sformatf("t1[%0d]/table", i), {g1, id1, b1, t1},
            {tab1[i].grant, tab1[i].gid, tab1[i].busy, tab1[i].to});
    end

    // Random traffic: requests persist for random stretches, with occasional resets.
    begin
      logic [2:0] cur;
      logic       r;
      cur = 3'b000;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 3) == 0) cur = 3'($urandom_range(0, 7));
        r = ($urandom_range(0, 79) == 0);
        step(r, cur, $sformatf("rnd[%0d]", n));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
